// File: rtl/flop_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : flop_bank_arbiter
// Brief   : Round-robin arbiter sharing one WIDTH-bit register among N
//           requesters, with capped burst lock and clear/preset/load ops.
// Revision: 1.0 - initial release
// ============================================================================
module flop_bank_arbiter #(
    parameter int               N         = 4,
    parameter int               WIDTH     = 8,
    parameter int               MAX_BURST = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N-1:0]           req,
    input  logic [2*N-1:0]         op,
    input  logic [N*WIDTH-1:0]     wdata,
    input  logic [N-1:0]           lock,
    output logic [N-1:0]           ack,
    output logic [$clog2(N)-1:0]   gnt_id,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);

    localparam int               c_IDW        = $clog2(N);
    localparam logic [0:0]       c_ARB        = 1'b0;
    localparam logic [0:0]       c_EXEC       = 1'b1;
    localparam logic [1:0]       c_OP_NOP     = 2'b00;
    localparam logic [1:0]       c_OP_LOAD    = 2'b01;
    localparam logic [1:0]       c_OP_CLEAR   = 2'b10;
    localparam logic [1:0]       c_OP_PRESET  = 2'b11;
    localparam logic [3:0]       c_BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [c_IDW-1:0] c_ID_MAX     = c_IDW'(N - 1);

    logic [0:0]       r_state;
    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW-1:0] r_gnt_id;
    logic [3:0]       r_cnt;
    logic             r_lock_active;
    logic             r_lock_lat;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [N-1:0]     r_ack;
    logic             r_busy;
    logic [WIDTH-1:0] r_q;

    logic [1:0]       w_op_arr   [N];
    logic [WIDTH-1:0] w_data_arr [N];
    logic [c_IDW-1:0] w_gnt_next;
    logic             w_release;
    logic             w_owner_hold;
    logic [c_IDW-1:0] w_ptr_eff;
    logic [N-1:0]     w_elig;
    logic             w_found;
    logic [c_IDW-1:0] w_win;
    logic [3:0]       w_cnt_eff;
    logic             w_take_lock;
    int               w_idx;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign w_op_arr[gi]   = op[2*gi +: 2];
            assign w_data_arr[gi] = wdata[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // While a lock is active the lock owner is always the last granted id.
    assign w_gnt_next   = (r_gnt_id == c_ID_MAX) ? '0 : r_gnt_id + 1'b1;
    assign w_release    = (r_state == c_ARB) && r_lock_active &&
                          (!req[r_gnt_id] || !lock[r_gnt_id]);
    assign w_owner_hold = r_lock_active && !w_release;
    assign w_ptr_eff    = w_release ? w_gnt_next : r_ptr;
    assign w_cnt_eff    = w_owner_hold ? r_cnt : 4'd0;
    assign w_take_lock  = lock[w_win] && (w_cnt_eff < c_BURST_LAST);

    // Descending scan so the lowest offset from the pointer wins last.
    always_comb begin
        w_elig = req & ~r_ack;
        if (w_owner_hold) begin
            w_elig = w_elig & (N'(1) << r_gnt_id);
        end
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(w_ptr_eff) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (w_elig[c_IDW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = c_IDW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= c_ARB;
            r_ptr         <= '0;
            r_gnt_id      <= '0;
            r_cnt         <= 4'd0;
            r_lock_active <= 1'b0;
            r_lock_lat    <= 1'b0;
            r_op          <= c_OP_NOP;
            r_data        <= '0;
            r_ack         <= '0;
            r_busy        <= 1'b0;
            r_q           <= RESET_VAL;
        end else begin
            case (r_state)
                c_ARB: begin
                    r_ack <= '0;
                    if (w_release) begin
                        r_lock_active <= 1'b0;
                        r_cnt         <= 4'd0;
                        r_ptr         <= w_gnt_next;
                    end
                    if (w_found) begin
                        r_state    <= c_EXEC;
                        r_busy     <= 1'b1;
                        r_gnt_id   <= w_win;
                        r_op       <= w_op_arr[w_win];
                        r_data     <= w_data_arr[w_win];
                        r_lock_lat <= w_take_lock;
                    end
                end
                c_EXEC: begin
                    case (r_op)
                        c_OP_LOAD:   r_q <= r_data;
                        c_OP_CLEAR:  r_q <= '0;
                        c_OP_PRESET: r_q <= '1;
                        default:     r_q <= r_q;
                    endcase
                    r_ack   <= N'(1) << r_gnt_id;
                    r_busy  <= 1'b0;
                    r_state <= c_ARB;
                    // A non-locked completion (incl. the capped final op) ends any burst.
                    if (r_lock_lat) begin
                        r_lock_active <= 1'b1;
                        r_cnt         <= r_lock_active ? r_cnt + 4'd1 : 4'd1;
                    end else begin
                        r_lock_active <= 1'b0;
                        r_cnt         <= 4'd0;
                        r_ptr         <= w_gnt_next;
                    end
                end
                default: r_state <= c_ARB;
            endcase
        end
    end

    assign ack    = r_ack;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;
    assign q      = r_q;

endmodule
`default_nettype wire

// File: tb/tb_flop_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_flop_bank_arbiter
// Brief   : Scoreboard bench for flop_bank_arbiter (N=4, WIDTH=8, MAX_BURST=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_flop_bank_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [3:0]  lock;
    logic [3:0]  ack;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [7:0]  q;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int         id;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    flop_bank_arbiter #(
        .N(4), .WIDTH(8), .MAX_BURST(4), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk), .clr(clr), .req(req), .op(op), .wdata(wdata),
        .lock(lock), .ack(ack), .gnt_id(gnt_id), .busy(busy), .q(q)
    );

    // Every ack must match the head of the scoreboard: requester, gnt_id and q.
    always @(negedge clk) begin
        if (ack !== 4'b0000) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_ack: ack=%b q=%h, required no ack", ack, q);
            end else begin
                mon_e = sb.pop_front();
                if (ack !== (4'b0001 << mon_e.id) || gnt_id !== 2'(mon_e.id) || q !== mon_e.val)
                    $display("FAIL sb_ack: ack=%b gnt_id=%0d q=%h, required ack=%b gnt_id=%0d q=%h",
                             ack, gnt_id, q, 4'b0001 << mon_e.id, mon_e.id, mon_e.val);
                else passed++;
            end
        end
    end

    function automatic exp_t mk(input int id, input logic [7:0] val);
        exp_t e;
        e.id  = id;
        e.val = val;
        return e;
    endfunction

    task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] d, input logic l);
        op[2*i +: 2]    = o;
        wdata[8*i +: 8] = d;
        lock[i]         = l;
        req[i]          = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr  = 1'b1;
        req  = '0;
        lock = '0;
        @(negedge clk);
        clr  = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; req = 4'hF; op = 8'h55; wdata = 32'hDEADBEEF; lock = '0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (q !== 8'h00 || ack !== 4'b0 || busy !== 1'b0 || gnt_id !== 2'd0)
                $display("FAIL reset_state: q=%h ack=%b busy=%b gnt=%0d, required 00/0000/0/0", q, ack, busy, gnt_id);
            else passed++;
        end
        clr = 1'b0; req = '0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || ack !== 4'b0) $display("FAIL idle_after_reset: busy=%b ack=%b, required 0/0000", busy, ack);
        else passed++;
        set_req(0, 2'b01, 8'h5A, 1'b0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL mid_exec_busy: busy=%b, required 1", busy);
        else passed++;
        clr = 1'b1; req = '0;
        @(negedge clk);
        total++;
        if (ack !== 4'b0 || q !== 8'h00 || busy !== 1'b0)
            $display("FAIL mid_exec_clr: ack=%b q=%h busy=%b, required 0000/00/0", ack, q, busy);
        else passed++;
        clr = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 4'b0 || q !== 8'h00) $display("FAIL clr_drop_op: ack=%b q=%h, required 0000/00", ack, q);
        else passed++;
    endtask

    task automatic test_single_load();
        set_req(1, 2'b01, 8'hA5, 1'b0);
        sb.push_back(mk(1, 8'hA5));
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || ack !== 4'b0) $display("FAIL load_t1: busy=%b ack=%b, required 1/0000", busy, ack);
        else passed++;
        @(negedge clk);
        total++;
        if (q !== 8'hA5 || ack !== 4'b0010 || busy !== 1'b0)
            $display("FAIL load_t2: q=%h ack=%b busy=%b, required a5/0010/0", q, ack, busy);
        else passed++;
        req[1] = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 4'b0 || busy !== 1'b0) $display("FAIL load_t3: ack=%b busy=%b, required 0000/0", ack, busy);
        else passed++;
    endtask

    task automatic test_op_values();
        logic [1:0] ops  [3] = '{2'b10, 2'b11, 2'b00};
        logic [7:0] vals [3] = '{8'h00, 8'hFF, 8'hFF};
        for (int k = 0; k < 3; k++) begin
            int lat = -1;
            set_req(0, ops[k], 8'h3C, 1'b0);
            sb.push_back(mk(0, vals[k]));
            for (int c = 0; c < 10 && lat < 0; c++) begin
                @(negedge clk);
                if (ack[0]) lat = c;
            end
            total++;
            if (lat != 1) $display("FAIL op_latency[%0d]: ack after %0d negedges, required 1", k, lat);
            else passed++;
            req[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int got = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 2'b01, 8'h10 + 8'(i), 1'b0);
            sb.push_back(mk(i, 8'h10 + 8'(i)));
        end
        sb.push_back(mk(0, 8'h50));
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                got++;
                if (ack[0]) wdata[7:0] = 8'h50;
                if (got == 5) req = '0;
            end
        end
        total++;
        if (got != 5) $display("FAIL rr_timeout: %0d acks, required 5", got);
        else passed++;
    endtask

    task automatic test_burst(input int drop_after);
        int got  = 0;
        int want = (drop_after == 0) ? 5 : drop_after + 1;
        do_reset();
        set_req(2, 2'b01, 8'h22, 1'b1);
        for (int k = 0; k < want - 1; k++) sb.push_back(mk(2, 8'h22));
        sb.push_back(mk(3, 8'h33));
        @(negedge clk);
        set_req(0, 2'b01, 8'h20, 1'b0);
        set_req(1, 2'b01, 8'h21, 1'b0);
        set_req(3, 2'b01, 8'h33, 1'b0);
        for (int c = 0; c < 80 && got < want; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                got++;
                if (drop_after != 0 && got == drop_after) lock[2] = 1'b0;
                if (got == want) begin req = '0; lock = '0; end
            end
        end
        total++;
        if (got != want) $display("FAIL burst_timeout(drop=%0d): %0d acks, required %0d", drop_after, got, want);
        else passed++;
    endtask

    task automatic test_ack_exclusion();
        int seen = 0;
        do_reset();
        set_req(0, 2'b01, 8'h33, 1'b0);
        sb.push_back(mk(0, 8'h33));
        sb.push_back(mk(0, 8'h44));
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (ack[0]) seen = 1;
        end
        wdata[7:0] = 8'h44;
        @(negedge clk);
        total++;
        if (seen != 1 || busy !== 1'b0 || ack !== 4'b0)
            $display("FAIL ack_excl_cycle: seen=%0d busy=%b ack=%b, required 1/0/0000", seen, busy, ack);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL ack_excl_regrant: busy=%b, required 1", busy);
        else passed++;
        @(negedge clk);
        total++;
        if (ack !== 4'b0001 || q !== 8'h44) $display("FAIL ack_excl_second: ack=%b q=%h, required 0001/44", ack, q);
        else passed++;
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        req = '0; op = '0; wdata = '0; lock = '0; clr = 1'b1;
        test_reset();
        test_single_load();
        test_op_values();
        test_round_robin();
        test_burst(0);
        test_burst(2);
        test_ack_exclusion();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d pending, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
